// File: rtl/miner_job_sequencer_pkg.sv
// Shared state encoding, result status codes and job byte layout for the miner job sequencer.
// Field offsets are byte positions from the first byte of the 80-byte job stream.
package miner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    REPORT
  } state_t;

  localparam logic [7:0] STATUS_FOUND     = 8'hA5;
  localparam logic [7:0] STATUS_EXHAUSTED = 8'h5A;

  localparam int JOB_BYTES    = 80;
  localparam int RESULT_BYTES = 5;
  localparam int JOB_BITS     = JOB_BYTES * 8;

  localparam int OFF_DIGEST_INITIAL = 0;
  localparam int OFF_DIGEST         = 32;
  localparam int OFF_MERKLE         = 64;
  localparam int OFF_TIME           = 68;
  localparam int OFF_TARGET         = 72;
  localparam int OFF_NONCE          = 76;

  // The first streamed byte ends up in the top byte of the job register.
  function automatic int field_msb(input int byte_off);
    return JOB_BITS - 1 - 8 * byte_off;
  endfunction

endpackage

// File: rtl/miner_job_sequencer_if.sv
// Receive/transmit byte handshakes and hasher job/result bus of the miner job sequencer.
// master is the sequencer side; slave is the side facing uart and hasher.
interface miner_job_sequencer_if;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         rx_ready;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready;
  logic         hash_write_en;
  logic [255:0] hash_digest_initial;
  logic [255:0] hash_digest;
  logic [31:0]  hash_merkle;
  logic [31:0]  hash_time;
  logic [31:0]  hash_target;
  logic [31:0]  hash_nonce;
  logic         hash_valid;
  logic [31:0]  hash_nonce_out;

  modport master (
    input  rx_valid, rx_data, tx_ready, hash_valid, hash_nonce_out,
    output rx_ready, tx_valid, tx_data, hash_write_en,
           hash_digest_initial, hash_digest, hash_merkle, hash_time, hash_target, hash_nonce
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, hash_valid, hash_nonce_out,
    input  rx_ready, tx_valid, tx_data, hash_write_en,
           hash_digest_initial, hash_digest, hash_merkle, hash_time, hash_target, hash_nonce
  );
endinterface

// File: rtl/miner_job_sequencer_result_packer.sv
// Serialises status + nonce as 5 bytes; first byte valid the cycle after load, one byte per cycle.
// tx_data is held while tx_ready is low; done strobes on the final handshake.
module result_packer
  import miner_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  load_status,
  input  logic [31:0] load_nonce,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [7:0]  status,
  output logic        done
);

  localparam logic [2:0] LAST_IDX = 3'(RESULT_BYTES - 1);

  logic [2:0]  idx;
  logic [31:0] nonce_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      idx      <= '0;
      status   <= '0;
      nonce_q  <= '0;
    end else if (load) begin
      tx_valid <= 1'b1;
      idx      <= '0;
      status   <= load_status;
      nonce_q  <= load_nonce;
    end else if (tx_valid && tx_ready) begin
      if (idx == LAST_IDX) begin
        tx_valid <= 1'b0;
        idx      <= '0;
      end else begin
        idx <= idx + 3'd1;
      end
    end
  end

  always_comb begin
    tx_data = status;
    case (idx)
      3'd1:    tx_data = nonce_q[31:24];
      3'd2:    tx_data = nonce_q[23:16];
      3'd3:    tx_data = nonce_q[15:8];
      3'd4:    tx_data = nonce_q[7:0];
      default: tx_data = status;
    endcase
  end

  assign done = tx_valid && tx_ready && (idx == LAST_IDX);

endmodule

// File: rtl/miner_job_sequencer.sv
// Loads an 80-byte job, strobes the hasher, watches a cycle budget and reports 5 result bytes; rx stalls outside IDLE/LOAD.
// MINER_JOB_SEQUENCER_RX_GAP_EN enables the receive-gap abort in LOAD (err pulse); otherwise err is 0.
module miner_job_sequencer
  import miner_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000,
  parameter logic [23:0] RX_GAP_CYCLES  = 24'd1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  miner_job_sequencer_if.master bus,
  output logic                  busy,
  output logic                  found,
  output logic                  err
);

  localparam logic [6:0] LAST_BYTE = 7'(JOB_BYTES - 1);
  localparam int MSB_DI = field_msb(OFF_DIGEST_INITIAL);
  localparam int MSB_DG = field_msb(OFF_DIGEST);
  localparam int MSB_MK = field_msb(OFF_MERKLE);
  localparam int MSB_TM = field_msb(OFF_TIME);
  localparam int MSB_TG = field_msb(OFF_TARGET);
  localparam int MSB_NC = field_msb(OFF_NONCE);

  state_t              state;
  logic [JOB_BITS-1:0] job_q;
  logic [JOB_BITS-1:0] job_shift;
  logic [6:0]          byte_cnt;
  logic [31:0]         cycle_cnt;
  logic                write_en_q;
  logic                rx_fire;
  logic                pack_load;
  logic [7:0]          pack_load_status;
  logic [31:0]         pack_load_nonce;
  logic [7:0]          pack_status;
  logic                pack_done;

`ifdef MINER_JOB_SEQUENCER_RX_GAP_EN
  // Bytes assemble in a staging copy so an aborted load leaves the previous job intact.
  logic [JOB_BITS-1:0] job_stage;
  logic [23:0]         gap_cnt;
  logic                err_q;
  assign job_shift = {job_stage[JOB_BITS-9:0], bus.rx_data};
  assign err       = err_q;
`else
  logic [23:0] rx_gap_unused;
  assign rx_gap_unused = RX_GAP_CYCLES;
  assign job_shift     = {job_q[JOB_BITS-9:0], bus.rx_data};
  assign err           = 1'b0;
`endif

  assign bus.rx_ready = !rst && (state == IDLE || state == LOAD);
  assign rx_fire      = bus.rx_valid && bus.rx_ready;

  // A find on the budget's last cycle still reports as found.
  assign pack_load        = (state == RUN) && (bus.hash_valid || cycle_cnt == TIMEOUT_CYCLES - 32'd1);
  assign pack_load_status = bus.hash_valid ? STATUS_FOUND : STATUS_EXHAUSTED;
  assign pack_load_nonce  = bus.hash_valid ? bus.hash_nonce_out : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      job_q      <= '0;
      byte_cnt   <= '0;
      cycle_cnt  <= '0;
      write_en_q <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
`ifdef MINER_JOB_SEQUENCER_RX_GAP_EN
      job_stage  <= '0;
      gap_cnt    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      write_en_q <= 1'b0;
`ifdef MINER_JOB_SEQUENCER_RX_GAP_EN
      err_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_fire) begin
`ifdef MINER_JOB_SEQUENCER_RX_GAP_EN
            job_stage <= job_shift;
            gap_cnt   <= '0;
`else
            job_q     <= job_shift;
`endif
            byte_cnt <= 7'd1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (rx_fire) begin
`ifdef MINER_JOB_SEQUENCER_RX_GAP_EN
            job_stage <= job_shift;
            gap_cnt   <= '0;
            if (byte_cnt == LAST_BYTE) job_q <= job_shift;
`else
            job_q     <= job_shift;
`endif
            byte_cnt <= byte_cnt + 7'd1;
            if (byte_cnt == LAST_BYTE) begin
              write_en_q <= 1'b1;
              state      <= START;
            end
          end
`ifdef MINER_JOB_SEQUENCER_RX_GAP_EN
          else if (gap_cnt == RX_GAP_CYCLES - 24'd1) begin
            byte_cnt <= '0;
            gap_cnt  <= '0;
            err_q    <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 24'd1;
          end
`endif
        end
        START: begin
          found     <= 1'b0;
          cycle_cnt <= '0;
          state     <= RUN;
        end
        RUN: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (pack_load) state <= REPORT;
        end
        REPORT: begin
          if (pack_done) begin
            found <= (pack_status == STATUS_FOUND);
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hash_write_en       = write_en_q;
  assign bus.hash_digest_initial = job_q[MSB_DI -: 256];
  assign bus.hash_digest         = job_q[MSB_DG -: 256];
  assign bus.hash_merkle         = job_q[MSB_MK -: 32];
  assign bus.hash_time           = job_q[MSB_TM -: 32];
  assign bus.hash_target         = job_q[MSB_TG -: 32];
  assign bus.hash_nonce          = job_q[MSB_NC -: 32];

  result_packer u_result_packer (
    .clk         (clk),
    .rst         (rst),
    .load        (pack_load),
    .load_status (pack_load_status),
    .load_nonce  (pack_load_nonce),
    .tx_ready    (bus.tx_ready),
    .tx_valid    (bus.tx_valid),
    .tx_data     (bus.tx_data),
    .status      (pack_status),
    .done        (pack_done)
  );

endmodule

// File: tb/tb_miner_job_sequencer.sv
// Bench for miner_job_sequencer: random jobs and hasher timing against a field-level result model.
// Expected tx bytes and job fields are queued at issue time and checked by independent monitors.
module tb_miner_job_sequencer;

  localparam int TO  = 16;
  localparam int GAP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, found, err;

  miner_job_sequencer_if bus();

  miner_job_sequencer #(
    .TIMEOUT_CYCLES (32'd16),
    .RX_GAP_CYCLES  (24'd8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .found (found),
    .err   (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] di;
    logic [255:0] dg;
    logic [31:0]  mk;
    logic [31:0]  tm;
    logic [31:0]  tg;
    logic [31:0]  nc;
  } job_t;

  job_t        job_q[$];
  int          d_q[$];
  logic [31:0] hn_q[$];
  logic [7:0]  exp_q[$];
  bit          found_q[$];
  bit          rand_tx = 1'b0;
  job_t        last_full_job;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic job_t rand_job();
    job_t r;
    for (int i = 0; i < 8; i++) begin
      r.di[32*i +: 32] = $urandom;
      r.dg[32*i +: 32] = $urandom;
    end
    r.mk = $urandom;
    r.tm = $urandom;
    r.tg = $urandom;
    r.nc = $urandom;
    return r;
  endfunction

  // d = 0: hasher never answers; d = k: hash_valid during the k-th RUN cycle.
  task automatic push_expect(input job_t j, input int d, input logic [31:0] hn);
    job_q.push_back(j);
    d_q.push_back(d);
    hn_q.push_back(hn);
    if (d >= 1 && d <= TO) begin
      exp_q.push_back(8'hA5);
      for (int i = 3; i >= 0; i--) exp_q.push_back(hn[8*i +: 8]);
      found_q.push_back(1'b1);
    end else begin
      exp_q.push_back(8'h5A);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
      found_q.push_back(1'b0);
    end
    last_full_job = j;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin
      bus.rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      ok = bus.rx_ready;
      @(posedge clk); #1;
    end
    if (!ok) fail_now("rx_accept_timeout");
  endtask

  task automatic send_range(input job_t j, input int from, input int to, input int max_gap);
    logic [639:0] jv;
    jv = {j.di, j.dg, j.mk, j.tm, j.tg, j.nc};
    for (int i = from; i < to; i++)
      send_byte(jv[639-8*i -: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    bus.rx_valid = 1'b0;
  endtask

  task automatic issue(input job_t j, input int d, input logic [31:0] hn, input int max_gap);
    push_expect(j, d, hn);
    send_range(j, 0, 80, max_gap);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || d_q.size() != 0) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) fail_now("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Hasher model: checks the loaded job and answers after the chosen delay.
  initial begin
    job_t        hj;
    int          hd;
    logic [31:0] hhn;
    bus.hash_valid     = 1'b0;
    bus.hash_nonce_out = $urandom;
    forever begin
      @(negedge clk);
      if (bus.hash_write_en === 1'b1) begin
        if (job_q.size() == 0) begin
          fail_now("spurious_write_en");
        end else begin
          hj  = job_q.pop_front();
          hd  = d_q.pop_front();
          hhn = hn_q.pop_front();
          check("hash_digest_initial", bus.hash_digest_initial, hj.di);
          check("hash_digest", bus.hash_digest, hj.dg);
          check("hash_merkle", bus.hash_merkle, hj.mk);
          check("hash_time", bus.hash_time, hj.tm);
          check("hash_target", bus.hash_target, hj.tg);
          check("hash_nonce", bus.hash_nonce, hj.nc);
          @(negedge clk);
          check("write_en_one_cycle", bus.hash_write_en, 1'b0);
          if (hd > 0) begin
            repeat (hd - 1) @(negedge clk);
            bus.hash_valid     = 1'b1;
            bus.hash_nonce_out = hhn;
            @(posedge clk); #1;
            bus.hash_valid     = 1'b0;
            bus.hash_nonce_out = $urandom;
            if (hd <= TO) begin
              check("result_latency_valid", bus.tx_valid, 1'b1);
              check("result_first_byte", bus.tx_data, 8'hA5);
            end
          end
        end
      end
    end
  end

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.tx_ready = rand_tx ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Result monitor / scoreboard.
  initial begin
    logic [7:0] held;
    bit         held_vld;
    bit         chk_found;
    bit         fexp;
    int         pidx;
    int         last_hs;
    held_vld  = 1'b0;
    chk_found = 1'b0;
    fexp      = 1'b0;
    pidx      = 0;
    last_hs   = 0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (chk_found) begin
        check("found_after_report", found, fexp);
        check("busy_after_report", busy, 1'b0);
        chk_found = 1'b0;
      end
      if (bus.tx_valid === 1'b1) begin
        check("rx_ready_low_in_report", bus.rx_ready, 1'b0);
        if (held_vld) check("tx_data_stable", bus.tx_data, held);
        if (bus.tx_ready) begin
          held_vld = 1'b0;
          if (exp_q.size() == 0) fail_now("unexpected_tx_byte");
          else check("tx_byte", bus.tx_data, exp_q.pop_front());
          if (pidx > 0 && !rand_tx) check("tx_no_bubble", cyc - last_hs, 1);
          last_hs = cyc;
          pidx++;
          if (pidx == 5) begin
            pidx      = 0;
            chk_found = 1'b1;
            fexp      = (found_q.size() != 0) ? found_q.pop_front() : 1'b0;
          end
        end else begin
          held_vld = 1'b1;
          held     = bus.tx_data;
        end
      end
    end
  end

  initial begin
    job_t j;
    int   t0;
    int   errk;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_valid", bus.tx_valid, 1'b0);
    check("reset_rx_ready", bus.rx_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_found", found, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_write_en", bus.hash_write_en, 1'b0);
    check("reset_job_regs", bus.hash_digest_initial, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rx_ready_idle", bus.rx_ready, 1'b1);
    @(posedge clk); #1;

    // Reference job, found after 5 RUN cycles.
    j.di = 256'hF59007B5_1C4E88A2_6D03F7E9_902B5C14_A7E3D061_4F88C2B9_E01D7A36_3BC75771;
    j.dg = 256'hF7A528B9_5E6F3C10_8B2D94A7_C31F0E58_72A9B6D4_0D5C81EF_A4693B27_FA09E776;
    j.mk = 32'h252DB801;
    j.tm = 32'h130DAE51;
    j.tg = 32'h6461011A;
    j.nc = 32'h3AEB9BB0;
    t0 = cyc;
    issue(j, 5, 32'h3AEB9BB0, 0);
    check("load_80_cycles", cyc - t0, 80);
    @(negedge clk);
    check("write_en_after_byte80", bus.hash_write_en, 1'b1);
    @(posedge clk); #1;

    issue(rand_job(), 0, $urandom, 0);   // budget exhausted
    issue(rand_job(), 16, $urandom, 0);  // find on the last budget cycle
    issue(rand_job(), 17, $urandom, 0);  // find just after the budget
    wait_drain();

    rand_tx = 1'b1;
    for (int n = 0; n < 12; n++)
      issue(rand_job(), int'($urandom_range(0, 20)), $urandom, 2);
    wait_drain();

    // Reset in the middle of a load, then a clean job.
    send_range(rand_job(), 0, 40, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midload_reset_busy", busy, 1'b0);
    check("midload_reset_found", found, 1'b0);
    check("midload_reset_rx_ready", bus.rx_ready, 1'b0);
    check("midload_reset_job", bus.hash_merkle, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(rand_job(), 3, $urandom, 1);
    wait_drain();

    j = rand_job();
`ifdef MINER_JOB_SEQUENCER_RX_GAP_EN
    send_range(j, 0, 40, 0);
    errk = 0;
    for (int k = 1; k <= 20 && errk == 0; k++) begin
      @(negedge clk);
      if (err) errk = k;
    end
    // Err rises on the GAP-th edge after the last accepted byte.
    check("err_after_gap", errk, GAP + 1);
    @(negedge clk);
    check("err_one_cycle", err, 1'b0);
    check("gap_abort_idle", bus.rx_ready, 1'b1);
    check("gap_abort_busy", busy, 1'b0);
    check("gap_abort_keeps_job", bus.hash_digest_initial, last_full_job.di);
    @(posedge clk); #1;
    issue(rand_job(), 2, $urandom, 0);
`else
    push_expect(j, 4, $urandom);
    send_range(j, 0, 40, 0);
    errk = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (err) errk++;
    end
    check("no_err_without_gap_abort", errk, 0);
    check("load_waits_busy", busy, 1'b1);
    check("load_waits_rx_ready", bus.rx_ready, 1'b1);
    @(posedge clk); #1;
    send_range(j, 40, 80, 0);
`endif
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/miner_job_sequencer.md
Name: miner_job_sequencer

Overview:
- Sequences the SHA hasher for one mining job at a time.
- Assembles an 80-byte job from the serial receive byte stream into job registers.
- Pulses the hasher load strobe, then supervises the search with a cycle-budget watchdog.
- Streams a 5-byte result packet (status + nonce) back to the serial transmitter; replaces the constant job hack at top level.

Parameters:
- TIMEOUT_CYCLES, 32'd100_000_000, RUN-state cycle budget before declaring exhaustion (1 s at 100 MHz); minimum 2.
- RX_GAP_CYCLES, 24'd1_000_000, max idle cycles between job bytes (used only with the optional feature).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  receive byte available
- rx_data  in  8  receive byte
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- tx_valid  out  1  result byte valid
- tx_data  out  8  result byte
- tx_ready  in  1  transmitter accepts byte
- hash_write_en  out  1  one-cycle load strobe to hasher
- hash_digest_initial  out  256  job field
- hash_digest  out  256  job field
- hash_merkle  out  32  job field
- hash_time  out  32  job field
- hash_target  out  32  job field
- hash_nonce  out  32  starting nonce
- hash_valid  in  1  hasher found solution (level or pulse)
- hash_nonce_out  in  32  winning nonce
- busy  out  1  high in LOAD/START/RUN/REPORT
- found  out  1  sticky, set on last found report, cleared on next job start or reset
- err  out  1  one-cycle pulse on aborted load (optional feature only)

Behaviour:
- Reset: state IDLE; all outputs 0; job registers 0; byte counter 0; cycle counter 0. Reset mid-operation abandons the job and any partial packet immediately.
- Job byte order: digest_initial[255:248] first through [7:0], then digest, merkle, time, target, nonce. Each field is MSB-byte first. 80 bytes total. Each accepted byte shifts into the concatenated 640-bit job register from the LSB end.
- rx_ready = 1 only in IDLE and LOAD; bytes offered in other states stall upstream and are never dropped.
- IDLE: on an accepted byte, store it, set count = 1, go to LOAD.
- LOAD: on each accepted byte, count++. Acceptance of byte 80 (count 79 -> 80) -> START. hash_* field outputs are driven directly from the job register and are stable from START onward.
- START: hash_write_en = 1 for exactly one cycle; clear found and the cycle counter -> RUN.
- RUN: the cycle counter increments every cycle.
  - hash_valid = 1: capture hash_nonce_out, status = 8'hA5 -> REPORT.
  - Counter == TIMEOUT_CYCLES-1: status = 8'h5A, nonce = 0 -> REPORT.
  - Both in the same cycle: found wins (8'hA5).
  - hash_valid asserted outside RUN is ignored.
- REPORT: transmits 5 bytes: status, then nonce[31:24], [23:16], [15:8], [7:0].
  - tx_valid held with tx_data stable until tx_ready; the index advances on tx_valid && tx_ready.
  - No bubble between bytes when tx_ready is held high, giving exactly 5 cycles.
  - After the 5th handshake: found = (status == 8'hA5), go to IDLE. The latency from hash_valid to the first tx_valid is 1 cycle.
- Job register retains the last job after completion; outputs are unchanged until the next load overwrites them.

Optional Feature:
- Macro: MINER_JOB_SEQUENCER_RX_GAP_EN.
- Defined: in LOAD, a gap counter is reset on each accepted byte. If RX_GAP_CYCLES cycles pass with no accepted byte, the partial job is discarded (count = 0, job registers keep old contents), err pulses one cycle, and the state returns to IDLE.
- Undefined: LOAD waits indefinitely; err is tied to 0 and RX_GAP_CYCLES is unused.

Decomposition:
- Package miner_pkg:
  - State encoding: IDLE, LOAD, START, RUN, REPORT.
  - Status constants: STATUS_FOUND = 8'hA5, STATUS_EXHAUSTED = 8'h5A.
  - JOB_BYTES = 80, RESULT_BYTES = 5.
  - Field byte offsets: 0, 32, 64, 68, 72, 76.
- One sub-module, result_packer: holds the status and nonce, serialises the 5 bytes with the tx handshake, and pulses done.

Test Plan:
- Stream 80 bytes (digest_initial F59007B5…3BC75771, digest F7A528B9…FA09E776, merkle 252DB801, time 130DAE51, target 6461011A, nonce 3AEB9BB0) with rx_valid held high → rx_ready high for 80 cycles; hash_write_en pulses once, 1 cycle after byte 80; all hash_* outputs equal the streamed values.
- In RUN, assert hash_valid with hash_nonce_out = 32'h3AEB9BB0 and tx_ready = 1 → tx bytes A5, 3A, EB, 9B, B0 on consecutive cycles; found = 1; state IDLE.
- TIMEOUT_CYCLES = 16, no hash_valid → after 16 RUN cycles tx bytes 5A, 00, 00, 00, 00; found = 0.
- hash_valid on the same cycle the counter hits TIMEOUT_CYCLES-1 → status A5 with the captured nonce.
- tx_ready toggled 1-0-0-1 randomly during REPORT → no byte lost or duplicated, tx_data stable while stalled; rx_ready = 0 throughout REPORT.
- Assert rst after byte 40 of a load, then send a full job → clean 80-byte load accepted; with MINER_JOB_SEQUENCER_RX_GAP_EN and RX_GAP_CYCLES = 8, stopping after byte 40 gives one err pulse 8 cycles later and a return to IDLE.
